// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable baud, data width, parity and stop bits.
// Mid-bit sampling, false-start rejection, error flags and a one-word holding register.
module uart_rx_cfg #(
    parameter int CLK_HZ    = 12_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int BIT_TICKS = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW        = $clog2(BIT_TICKS);
    localparam int BW        = 4;

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_PAR       = 3'd4,
        S_STOP      = 3'd5
    } state_t;

    function automatic logic par_expect(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d;
    logic                   rs_q, rs_d;
    logic                   rs_prev_q, rs_prev_d;
    logic [1:0]             settle_q, settle_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   commit_q, commit_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic                   tick_s;
    logic                   stop_err_s;

    assign tick_s     = (cnt_q == CW'(0));
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

    // Synchroniser path; settle_q blocks WAIT_IDLE until rs reflects the line sampled after reset,
    // so a line held low through reset is never mistaken for a start edge.
    always_comb begin
        sync1_d   = rx;
        rs_d      = sync1_q;
        rs_prev_d = rs_q;
        if (settle_q == 2'd2) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + 2'd1;
        end
    end

    // Receive FSM: next state, bit timing and frame assembly
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        commit_d   = 1'b0;
        stop_err_s = ferr_q | ~rs_q;
        case (state_q)
            S_WAIT_IDLE: begin
                if ((settle_q == 2'd2) && rs_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            S_IDLE: begin
                if (rs_prev_q && !rs_q) begin
                    cnt_d   = CW'(BIT_TICKS / 2 - 1);
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rs_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CW'(BIT_TICKS - 1);
                    bit_d   = BW'(0);
                    shift_d = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d   = CW'(BIT_TICKS - 1);
                    shift_d = {rs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = BW'(0);
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PAR: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d   = CW'(BIT_TICKS - 1);
                    perr_d  = (rs_q != par_expect(shift_q));
                    bit_d   = BW'(0);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    ferr_d = stop_err_s;
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        commit_d = 1'b1;
                        state_d  = stop_err_s ? S_WAIT_IDLE : S_IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                        cnt_d = CW'(BIT_TICKS - 1);
                    end
                end
            end
            default: begin
                state_d = S_WAIT_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_WAIT_IDLE);
    end

    // Holding register: commit a finished frame or report overrun; handshake empties it
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (commit_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                frame_err_d  = ferr_q;
                parity_err_d = perr_q;
                overrun_d    = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d   = 1'b0;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT_IDLE;
            sync1_q      <= 1'b1;
            rs_q         <= 1'b1;
            rs_prev_q    <= 1'b1;
            settle_q     <= 2'd0;
            cnt_q        <= CW'(0);
            bit_q        <= BW'(0);
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            commit_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rs_q         <= rs_d;
            rs_prev_q    <= rs_prev_d;
            settle_q     <= settle_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            commit_q     <= commit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and an 8E1 instance, each driven with serial frames
// and checked against a frame-level model of the holding register.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int BT = 104;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] d0, d1;
    logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       ov;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       ec0, ec1;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_d0 = 8'h00, last_d1 = 8'h00;
    logic       last_fe0 = 1'b0, last_pe1 = 1'b0;

    always #41.667 clk = ~clk;

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .rx(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(b0)
    );

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .rx(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(b1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input int inst, input logic v, input int n);
        if (inst == 0) rx0 = v; else rx1 = v;
        cycles(n);
    endtask

    // Model: a frame lands in the holding register unless the consumer is stalled on an
    // unread word, in which case it is lost and the held word gains the overrun flag.
    task automatic send(input int inst, input logic [7:0] d, input logic pbit,
                        input logic sbit, input int tail_low);
        exp_t e, h;
        e.d  = d;
        e.fe = ~sbit;
        e.pe = (inst == 1) && (pbit != ^d);
        e.ov = 1'b0;
        if (inst == 0 && !rdy0 && q0.size() > 0) begin
            h = q0.pop_front();
            h.ov = 1'b1;
            q0.push_front(h);
        end else if (inst == 0) begin
            q0.push_back(e);
        end else begin
            q1.push_back(e);
        end
        hold(inst, 1'b0, BT);
        for (int i = 0; i < 8; i++) hold(inst, d[i], BT);
        if (inst == 1) hold(inst, pbit, BT);
        hold(inst, sbit, BT);
        if (tail_low > 0) hold(inst, 1'b0, tail_low);
        if (inst == 0) rx0 = 1'b1; else rx1 = 1'b1;
    endtask

    // Compare every accepted word against the model's next expected frame
    always @(negedge clk) begin
        if (!rst) begin
            if (v0 && rdy0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_word0", 32'(v0), 32'd0);
                end else begin
                    ec0 = q0.pop_front();
                    chk("data0", 32'(d0), 32'(ec0.d));
                    chk("ferr0", 32'(fe0), 32'(ec0.fe));
                    chk("perr0", 32'(pe0), 32'(ec0.pe));
                    chk("ovr0", 32'(ov0), 32'(ec0.ov));
                    last_d0  = d0;
                    last_fe0 = fe0;
                end
            end
            if (v1 && rdy1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_word1", 32'(v1), 32'd0);
                end else begin
                    ec1 = q1.pop_front();
                    chk("data1", 32'(d1), 32'(ec1.d));
                    chk("ferr1", 32'(fe1), 32'(ec1.fe));
                    chk("perr1", 32'(pe1), 32'(ec1.pe));
                    chk("ovr1", 32'(ov1), 32'(ec1.ov));
                    last_d1  = d1;
                    last_pe1 = pe1;
                end
            end
        end
    end

    initial begin
        logic [7:0] rd;
        logic       sb, pb;
        cycles(5);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_data", 32'(d0), 32'd0);
        chk("rst_flags", 32'({fe0, pe0, ov0}), 32'd0);
        chk("rst_busy", 32'({b0, b1}), 32'd0);
        rst = 1'b0;
        cycles(5);

        // Clean 8N1 word
        send(0, 8'h33, 1'b0, 1'b1, 0);
        cycles(3 * BT);
        chk("t1_drained", 32'(q0.size()), 32'd0);
        chk("t1_data", 32'(last_d0), 32'h33);

        // Even parity: correct then wrong parity bit
        send(1, 8'h37, 1'b1, 1'b1, 0);
        cycles(3 * BT);
        chk("t2_drained", 32'(q1.size()), 32'd0);
        chk("t2_perr_clean", 32'(last_pe1), 32'd0);
        send(1, 8'h37, 1'b0, 1'b1, 0);
        cycles(3 * BT);
        chk("t2_data", 32'(last_d1), 32'h37);
        chk("t2_perr_set", 32'(last_pe1), 32'd1);

        // Framing error with line held low, then recovery
        send(0, 8'h0A, 1'b0, 1'b0, 2 * BT);
        cycles(BT);
        chk("t3_ferr", 32'(last_fe0), 32'd1);
        chk("t3_data", 32'(last_d0), 32'h0A);
        send(0, 8'h33, 1'b0, 1'b1, 0);
        cycles(3 * BT);
        chk("t3_next_ferr", 32'(last_fe0), 32'd0);
        chk("t3_next_data", 32'(last_d0), 32'h33);

        // Short glitch must be rejected as a false start
        hold(0, 1'b0, 24);
        chk("t4_busy_mid", 32'(b0), 32'd1);
        hold(0, 1'b1, 2 * BT);
        chk("t4_busy_after", 32'(b0), 32'd0);
        chk("t4_no_word", 32'(v0), 32'd0);

        // Overrun with stalled consumer
        rdy0 = 1'b0;
        send(0, 8'h33, 1'b0, 1'b1, 0);
        send(0, 8'h37, 1'b0, 1'b1, 0);
        cycles(2 * BT);
        chk("t5_valid", 32'(v0), 32'd1);
        chk("t5_data", 32'(d0), 32'h33);
        chk("t5_ovr", 32'(ov0), 32'd1);
        rdy0 = 1'b1;
        cycles(2);
        chk("t5_cleared", 32'({v0, fe0, pe0, ov0}), 32'd0);
        chk("t5_drained", 32'(q0.size()), 32'd0);

        // Reset mid-data while the line is low
        hold(0, 1'b0, BT);
        hold(0, 1'b1, 2 * BT);
        hold(0, 1'b0, BT / 2);
        chk("t6_busy_pre", 32'(b0), 32'd1);
        rst = 1'b1;
        hold(0, 1'b0, 4);
        rst = 1'b0;
        cycles(2);
        chk("t6_out_zero", 32'({v0, fe0, pe0, ov0, b0}), 32'd0);
        chk("t6_data_zero", 32'(d0), 32'd0);
        hold(0, 1'b0, 2 * BT);
        chk("t6_low_not_start", 32'(b0), 32'd0);
        hold(0, 1'b1, 2 * BT);
        send(0, 8'h37, 1'b0, 1'b1, 0);
        cycles(3 * BT);
        chk("t6_next_data", 32'(last_d0), 32'h37);

        // Random traffic on both instances
        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom);
            sb = ($urandom_range(0, 7) != 0);
            send(0, rd, 1'b0, sb, 0);
            hold(0, 1'b1, sb ? $urandom_range(0, 2 * BT) : $urandom_range(4, 2 * BT));
        end
        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom);
            pb = (^rd) ^ ($urandom_range(0, 3) == 0);
            send(1, rd, pb, 1'b1, 0);
            hold(1, 1'b1, $urandom_range(0, 2 * BT));
        end
        cycles(3 * BT);
        chk("final_drained0", 32'(q0.size()), 32'd0);
        chk("final_drained1", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
